// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : intersection_phase_scheduler                                    |
// | Purpose  : One-green-at-a-time phase scheduler for four approaches with    |
// |            min/max green, fixed yellow and all-red, round-robin selection. |
// | Option   : EMERGENCY_PREEMPT_EN adds preempt / preempt_id ports.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module intersection_phase_scheduler #(
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] request,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_id,
`endif
    output logic [7:0] lights,
    output logic [1:0] active,
    output logic [1:0] phase
);

    localparam logic [1:0] PH_GREEN   = 2'd0;
    localparam logic [1:0] PH_YELLOW  = 2'd1;
    localparam logic [1:0] PH_ALL_RED = 2'd2;

    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    localparam logic [CNT_W-1:0] MIN_LAST     = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);

    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic [1:0]       phase_next;
    logic [1:0]       active_next;
    logic [7:0]       lights_next;
    logic             own;
    logic             other;
    logic             normal_exit;
    logic             green_exit;
    logic [1:0]       rr_next;
    logic [1:0]       grant_next;

    // First set request bit searching active+1, +2, +3, then active itself.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] req);
        logic [1:0] cand;
        rr_pick = cur;
        for (int k = 3; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (req[cand]) rr_pick = cand;
        end
    endfunction

    assign own         = request[active];
    assign other       = |(request & ~(4'b0001 << active));
    assign normal_exit = (timer >= MIN_LAST) && other && (!own || (timer >= MAX_LAST));
    assign rr_next     = rr_pick(active, request);

`ifdef EMERGENCY_PREEMPT_EN
    // Preemption bypasses MIN_GREEN, and freezes green on the preempted approach.
    assign green_exit  = preempt ? (active != preempt_id) : normal_exit;
    assign grant_next  = preempt ? preempt_id : rr_next;
`else
    assign green_exit  = normal_exit;
    assign grant_next  = rr_next;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            phase  <= PH_GREEN;
            active <= 2'd0;
            timer  <= '0;
            lights <= 8'h02;
        end else begin
            phase  <= phase_next;
            active <= active_next;
            timer  <= timer_next;
            lights <= lights_next;
        end
    end

    always_comb begin
        phase_next  = phase;
        active_next = active;
        timer_next  = timer + CNT_W'(1);
        case (phase)
            PH_GREEN: begin
                if (timer >= MAX_LAST) timer_next = MAX_LAST;
                if (green_exit) begin
                    phase_next = PH_YELLOW;
                    timer_next = '0;
                end
            end
            PH_YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    phase_next = PH_ALL_RED;
                    timer_next = '0;
                end
            end
            PH_ALL_RED: begin
                if (timer == ALL_RED_LAST) begin
                    phase_next  = PH_GREEN;
                    timer_next  = '0;
                    active_next = grant_next;
                end
            end
            default: begin
                phase_next = PH_GREEN;
                timer_next = '0;
            end
        endcase
    end

    // Lights are computed from the next state so the registered copy matches phase/active.
    always_comb begin
        lights_next = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (active_next == 2'(i)) begin
                if (phase_next == PH_GREEN)
                    lights_next[2*i +: 2] = LIGHT_GREEN;
                else if (phase_next == PH_YELLOW)
                    lights_next[2*i +: 2] = LIGHT_YELLOW;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// Testbench for intersection_phase_scheduler: directed scenarios plus randomized
// request traffic checked against a behavioural model of the phase rules.
module tb_intersection_phase_scheduler;

    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YEL_T = 3;
    localparam int AR_T  = 2;

    logic       clock;
    logic       clear;
    logic [3:0] request;
    logic [7:0] lights;
    logic [1:0] active;
    logic [1:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
    logic [1:0] preempt_id;
`endif

    int checks;
    int errors;

    int m_phase;
    int m_active;
    int m_timer;

    intersection_phase_scheduler #(
        .MIN_GREEN   (MIN_G),
        .MAX_GREEN   (MAX_G),
        .YELLOW_TIME (YEL_T),
        .ALL_RED_TIME(AR_T),
        .CNT_W       (8)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .request   (request),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt   (preempt),
        .preempt_id(preempt_id),
`endif
        .lights    (lights),
        .active    (active),
        .phase     (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Behavioural model: advance one cycle using the inputs presented before the edge.
    task automatic model_step();
        bit own, other, leave, found;
        int nxt;
        if (clear) begin
            m_phase = 0; m_active = 0; m_timer = 0;
            return;
        end
        if (m_phase == 0) begin
            own = request[m_active];
            other = 0;
            for (int j = 0; j < 4; j++)
                if (j != m_active && request[j]) other = 1;
            leave = (m_timer >= MIN_G - 1) && other && (!own || m_timer >= MAX_G - 1);
`ifdef EMERGENCY_PREEMPT_EN
            if (preempt) leave = (m_active != int'(preempt_id));
`endif
            if (leave) begin
                m_phase = 1; m_timer = 0;
            end else if (m_timer < MAX_G - 1) begin
                m_timer++;
            end
        end else if (m_phase == 1) begin
            if (m_timer == YEL_T - 1) begin
                m_phase = 2; m_timer = 0;
            end else m_timer++;
        end else begin
            if (m_timer == AR_T - 1) begin
                nxt = m_active;
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && request[(m_active + k) % 4]) begin
                        nxt = (m_active + k) % 4;
                        found = 1;
                    end
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt) nxt = int'(preempt_id);
`endif
                m_phase = 0; m_timer = 0; m_active = nxt;
            end else m_timer++;
        end
    endtask

    function automatic logic [7:0] model_lights();
        logic [7:0] v;
        v = 8'h00;
        if (m_phase == 0)      v[2*m_active +: 2] = 2'd2;
        else if (m_phase == 1) v[2*m_active +: 2] = 2'd1;
        return v;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        request = 4'b0000;
        do_clear();
        checks++; if (lights !== 8'h02) begin errors++; $display("FAIL reset_lights got %h want 02", lights); end
        checks++; if (active !== 2'd0) begin errors++; $display("FAIL reset_active got %0d want 0", active); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (dut.timer !== 8'd0) begin errors++; $display("FAIL reset_timer got %0d want 0", dut.timer); end
    endtask

    task automatic test_gap_out();
        logic [7:0] exp;
        do_clear();
        request = 4'b0100;
        for (int i = 0; i <= 9; i++) begin
            exp = (i < 4) ? 8'h02 : (i < 7) ? 8'h01 : (i < 9) ? 8'h00 : 8'h20;
            checks++;
            if (lights !== exp) begin errors++; $display("FAIL gap_out cycle %0d lights got %h want %h", i, lights, exp); end
            if (i < 9) tick();
        end
        checks++; if (active !== 2'd2) begin errors++; $display("FAIL gap_out_active got %0d want 2", active); end
    endtask

    task automatic test_max_out();
        logic [7:0] exp;
        do_clear();
        request = 4'b0011;
        for (int i = 0; i <= 15; i++) begin
            exp = (i < 10) ? 8'h02 : (i < 13) ? 8'h01 : (i < 15) ? 8'h00 : 8'h08;
            checks++;
            if (lights !== exp) begin errors++; $display("FAIL max_out cycle %0d lights got %h want %h", i, lights, exp); end
            if (i < 15) tick();
        end
        checks++; if (active !== 2'd1) begin errors++; $display("FAIL max_out_active got %0d want 1", active); end
    endtask

    task automatic test_round_robin();
        do_clear();
        request = 4'b1000;
        run(9);
        checks++; if (active !== 2'd3 || lights !== 8'h80) begin errors++; $display("FAIL rr_setup active %0d lights %h want 3 80", active, lights); end
        request = 4'b0101;
        run(9);
        checks++; if (active !== 2'd0 || lights !== 8'h02) begin errors++; $display("FAIL rr_wrap active %0d lights %h want 0 02", active, lights); end
        request = 4'b1000;
        run(9);
        request = 4'b0001;
        run(4);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL rr_to_yellow phase got %0d want 1", phase); end
        request = 4'b0000;
        run(5);
        checks++; if (active !== 2'd3 || phase !== 2'd0 || lights !== 8'h80) begin
            errors++; $display("FAIL rr_none active %0d phase %0d lights %h want 3 0 80", active, phase, lights);
        end
    endtask

    task automatic test_no_contention();
        int bad;
        do_clear();
        request = 4'b0001;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (lights !== 8'h02) begin errors++; bad++; if (bad < 5) $display("FAIL hold_green cycle %0d lights got %h want 02", i, lights); end
        end
        checks++; if (dut.timer !== 8'(MAX_G - 1)) begin errors++; $display("FAIL timer_saturate got %0d want %0d", dut.timer, MAX_G - 1); end
    endtask

    task automatic test_clear_mid_yellow();
        do_clear();
        request = 4'b0100;
        run(5);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL mid_yellow_setup phase got %0d want 1", phase); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (lights !== 8'h02) begin errors++; $display("FAIL clear_yellow_lights got %h want 02", lights); end
        checks++; if (dut.timer !== 8'd0) begin errors++; $display("FAIL clear_yellow_timer got %0d want 0", dut.timer); end
        checks++; if (phase !== 2'd0 || active !== 2'd0) begin errors++; $display("FAIL clear_yellow_state phase %0d active %0d want 0 0", phase, active); end
    endtask

`ifdef EMERGENCY_PREEMPT_EN
    task automatic test_preempt();
        do_clear();
        request = 4'b0010;
        run(10);
        checks++; if (active !== 2'd1 || lights !== 8'h08) begin errors++; $display("FAIL pre_setup active %0d lights %h want 1 08", active, lights); end
        preempt = 1'b1;
        preempt_id = 2'd3;
        tick();
        checks++; if (phase !== 2'd1 || lights !== 8'h04) begin errors++; $display("FAIL pre_yellow phase %0d lights %h want 1 04", phase, lights); end
        run(5);
        checks++; if (active !== 2'd3 || lights !== 8'h80) begin errors++; $display("FAIL pre_grant active %0d lights %h want 3 80", active, lights); end
        request = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (lights !== 8'h80) begin errors++; $display("FAIL pre_hold cycle %0d lights %h want 80", i, lights); end
        end
        preempt = 1'b0;
        tick();
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL pre_release phase got %0d want 1", phase); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] exp_l;
        int bad;
        bad = 0;
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) request = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 63) == 0);
`ifdef EMERGENCY_PREEMPT_EN
            if ($urandom_range(0, 39) == 0) begin
                preempt = ~preempt;
                preempt_id = 2'($urandom_range(0, 3));
            end
`endif
            tick();
            exp_l = model_lights();
            checks++;
            if (lights !== exp_l || active !== 2'(m_active) || phase !== 2'(m_phase)) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL random cycle %0d lights/active/phase got %h/%0d/%0d want %h/%0d/%0d",
                             i, lights, active, phase, exp_l, m_active, m_phase);
            end
        end
        clear = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        preempt = 1'b0;
`endif
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clear   = 1'b0;
        request = 4'b0000;
        m_phase = 0; m_active = 0; m_timer = 0;
`ifdef EMERGENCY_PREEMPT_EN
        preempt    = 1'b0;
        preempt_id = 2'd0;
`endif
        test_reset();
        test_gap_out();
        test_max_out();
        test_round_robin();
        test_no_contention();
        test_clear_mid_yellow();
`ifdef EMERGENCY_PREEMPT_EN
        test_preempt();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
